pwm_peripheral: RTL
===================

# pwm_peripheral

Output stage driving 16 digital pins from the configuration registers written over SPI. It consumes the five 8-bit register outputs of the SPI register block and produces per-pin static-high or PWM waveforms at one shared duty cycle. The block is fully synchronous to the system clock. Duty-cycle updates are double-buffered so each PWM period is glitch-free.

## Interface
**Parameters**
- `CLK_DIV`, default 13: prescaler ratio. With a 10 MHz `clk`, PWM frequency = 10 MHz / (13·256) ≈ 3.0 kHz. Legal range 1..255.

**Ports**
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en_reg_out_7_0`  in  8  output enable for pins 7..0.
- `en_reg_out_15_8`  in  8  output enable for pins 15..8.
- `en_reg_pwm_7_0`  in  8  PWM-mode select for pins 7..0.
- `en_reg_pwm_15_8`  in  8  PWM-mode select for pins 15..8.
- `pwm_duty_cycle`  in  8  duty cycle, 0x00 = 0 %, 0xFF = 100 %.
- `out`  out  16  pin drive; bit i corresponds to pin i.
- `pwm_sync`  out  1  one-`clk` pulse marking the start of each PWM period.

## Operation
- **Prescaler `presc_cnt`** (8 bit): counts 0..CLK_DIV-1, then wraps to 0.
  - `tick` = (presc_cnt == CLK_DIV-1).
  - With CLK_DIV=1, `tick` is asserted every cycle.
- **Period counter `pwm_cnt`** (8 bit): increments on `tick`, wrapping 255→0. A period is 256 ticks, i.e. 256·CLK_DIV clocks.
- **Duty shadow `duty_q`** (8 bit):
  - Loads `pwm_duty_cycle` on the `tick` where pwm_cnt==255, i.e. on the same edge pwm_cnt becomes 0.
  - Input changes mid-period have no effect until the next period.
- **PWM level `lvl`** (combinational): `lvl` = 1 if duty_q==0xFF, else (pwm_cnt < duty_q).
  - duty_q==0x00 gives constant 0.
  - duty_q==N (1..254) gives N·CLK_DIV high clocks per period, starting at period start.
- **Per-pin select**, with `en_out` = {en_reg_out_15_8, en_reg_out_7_0} and `en_pwm` = {en_reg_pwm_15_8, en_reg_pwm_7_0}:
  - en_out[i]=0 → 0, regardless of en_pwm[i].
  - en_out[i]=1, en_pwm[i]=0 → 1 (static high).
  - en_out[i]=1, en_pwm[i]=1 → lvl.
- Enable inputs are not double-buffered; they take effect per the timing below.
- `pwm_sync` is registered. It is high for exactly one clock: the clock in which pwm_cnt==0 and presc_cnt==0.
- **Reset** (asynchronous, any time, including mid-period): presc_cnt=0, pwm_cnt=0, duty_q=0x00, out=16'h0000, pwm_sync=0.
- **First period after reset**: duty_q stays 0. PWM pins stay low until the first reload, 256·CLK_DIV clocks after reset release.

## Timing
- `out` is registered: out[i] at edge k+1 reflects the inputs, pwm_cnt and duty_q sampled at edge k. This gives one-clock latency from any enable change to the pin.
- Duty change latency: the new value appears in the first period starting after the change. Worst case is 256·CLK_DIV + 1 clocks.
- **Transitions within one period** (0 < duty_q < 0xFF):
  - PWM pins rise one clock after pwm_cnt becomes 0.
  - PWM pins fall one clock after pwm_cnt becomes duty_q.
  - All PWM-mode pins switch on the same edge; there is no per-pin skew.
- Duty 0x00 or 0xFF: no edges on PWM pins.
- **Simultaneous events**:
  - A `pwm_duty_cycle` change on the reload edge itself is captured, because the input is sampled at that edge.
  - An enable change on a period boundary applies one clock later, the same as at any other time.
- **Counter chain**: pwm_cnt changes only on `tick`. presc_cnt never exceeds CLK_DIV-1.

## Test plan
- **Reset state**: assert rst_n=0 mid-period with out active → out=0x0000 and pwm_sync=0 immediately, asynchronously. After release, the first pwm_sync arrives 256·13 = 3328 clocks later.
- **Static mode**: en_out=0x00FF, en_pwm=0x0000, duty=0x80 → out=0x00FF constant one clock after the enables are applied. No toggling over 2 periods.
- **PWM 50 %**: en_out=0xFFFF, en_pwm=0xFFFF, duty=0x80 (CLK_DIV=13) → from the 2nd period, each pin is high 1664 and low 1664 clocks. Period is 3328 clocks, about 3.0 kHz.
- **Duty boundaries**: with en_out=en_pwm=0x0001:
  - duty=0x00 → out[0] constant 0 across a full period.
  - duty=0xFF → out[0] constant 1.
  - duty=0x01 → out[0] high for 13 clocks per period.
- **Mid-period duty change**: duty 0x40→0xC0 written at pwm_cnt=0x20 → the current period keeps a 0x40·13 = 832-clock high time. The next period has a 0xC0·13 = 2496-clock high time.
- **Mixed pins and enable gating**: en_out=0xA5A5, en_pwm=0x0F0F, duty=0x40:
  - Bits {0,2,8,10} PWM.
  - Bits {5,7,13,15} static 1.
  - All other bits 0.
  - Then clear en_out → all 0 one clock later, mid-pulse.

Source files
------------

// File: rtl/pwm_peripheral.sv
// 16-pin output stage: static-high or shared-duty PWM per pin, driven by the SPI
// register block; duty cycle is double-buffered and reloaded at each period start.
module pwm_peripheral #(
   parameter int CLK_DIV = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        pwm_sync
);

   localparam logic [7:0] PRESC_MAX = 8'(CLK_DIV - 1);

   logic [7:0]  presc_cnt;
   logic [7:0]  pwm_cnt;
   logic [7:0]  duty_q;
   logic        tick;
   logic        period_end;
   logic        lvl;
   logic [15:0] en_out;
   logic [15:0] en_pwm;

   always_comb begin
      en_out     = {en_reg_out_15_8, en_reg_out_7_0};
      en_pwm     = {en_reg_pwm_15_8, en_reg_pwm_7_0};
      tick       = (presc_cnt == PRESC_MAX);
      period_end = tick && (pwm_cnt == 8'hFF);
      // 0xFF is forced to a solid high; a plain compare would leave one tick low
      lvl        = (duty_q == 8'hFF) || (pwm_cnt < duty_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_cnt <= '0;
         pwm_cnt   <= '0;
         duty_q    <= '0;
         out       <= '0;
         pwm_sync  <= 1'b0;
      end else begin
         presc_cnt <= tick ? '0 : presc_cnt + 8'd1;
         if (tick) begin
            pwm_cnt <= pwm_cnt + 8'd1;
         end
         if (period_end) begin
            duty_q <= pwm_duty_cycle;
         end
         // Sync marks the clock where both counters sit at zero after a wrap,
         // so the idle zero state straight out of reset does not pulse it.
         pwm_sync  <= period_end;
         out       <= en_out & (~en_pwm | {16{lvl}});
      end
   end

endmodule
